// File: rtl/gen_wave_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gen_wave_pkg : shared types and sizing for the wave sweep controller  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package gen_wave_pkg;

   localparam int SIZE_DEPTH  = 1024;
   localparam int PHASE_W_DEF = $clog2(SIZE_DEPTH);

   typedef enum logic [1:0] {
      MODE_SINGLE_UP   = 2'b00,
      MODE_SINGLE_DOWN = 2'b01,
      MODE_PING_PONG   = 2'b10,
      MODE_REPEAT_UP   = 2'b11
   } sweep_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_DWELL     = 2'd1,
      ST_WAIT_WRAP = 2'd2
   } sweep_state_e;

endpackage
`default_nettype wire

// File: rtl/sweep_dwell_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sweep_dwell_timer : loadable down-counter, expired while at zero      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sweep_dwell_timer #(
   parameter int DWELL_W = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_load,
   input  logic [DWELL_W-1:0] i_load_val,
   input  logic               i_count,
   output logic               o_expired
);

   logic [DWELL_W-1:0] cnt_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else if (i_load) begin
         cnt_q <= i_load_val;
      end else if (i_count && (cnt_q != '0)) begin
         cnt_q <= cnt_q - DWELL_W'(1);
      end
   end

   assign o_expired = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/wave_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wave_sweep_ctrl : steps the wave-generator phase increment between   |
// | two bounds, one update per table wrap after a programmable dwell     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wave_sweep_ctrl
   import gen_wave_pkg::*;
#(
   parameter int PHASE_W = PHASE_W_DEF,
   parameter int DWELL_W = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic               i_stop,
   input  logic [1:0]         i_mode,
   input  logic [PHASE_W-1:0] i_step_lo,
   input  logic [PHASE_W-1:0] i_step_hi,
   input  logic [PHASE_W-1:0] i_step_inc,
   input  logic [DWELL_W-1:0] i_dwell,
   input  logic               i_wrap,
   output logic [PHASE_W-1:0] o_phase_step,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_dir,
   output logic               o_cfg_err
);

   sweep_state_e       state_q;
   sweep_mode_e        mode_q;
   logic [PHASE_W-1:0] lo_q, hi_q, inc_q, phase_q;
   logic [DWELL_W-1:0] dwell_q;
   logic               busy_q, done_q, dir_q, cfg_err_q;

   logic               cfg_bad, start_ok, wrap_take, terminal;
   logic               tmr_load, tmr_expired;
   logic [DWELL_W-1:0] tmr_src, tmr_val;
   logic [PHASE_W:0]   up_sum, dn_diff;
   logic [PHASE_W-1:0] up_val, dn_val, step_d;
   logic               dir_d;

   assign cfg_bad   = (i_step_lo > i_step_hi) || (i_step_inc == '0);
   assign start_ok  = (state_q == ST_IDLE) && i_start && !i_stop && !cfg_bad;
   assign wrap_take = (state_q == ST_WAIT_WRAP) && i_wrap && !i_stop;
   assign terminal  = dir_q ? (phase_q == lo_q) : (phase_q == hi_q);

   // Timer holds (dwell-1) so that expiry lands on the last held cycle; dwell 0 acts as 1.
   assign tmr_load = start_ok || wrap_take;
   assign tmr_src  = start_ok ? i_dwell : dwell_q;
   assign tmr_val  = (tmr_src == '0) ? '0 : tmr_src - DWELL_W'(1);

   sweep_dwell_timer #(
      .DWELL_W (DWELL_W)
   ) u_dwell_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (tmr_load),
      .i_load_val (tmr_val),
      .i_count    ((state_q == ST_DWELL) && !i_stop),
      .o_expired  (tmr_expired)
   );

   // One extra bit catches both overshoot past hi and borrow below zero.
   assign up_sum  = {1'b0, phase_q} + {1'b0, inc_q};
   assign dn_diff = {1'b0, phase_q} - {1'b0, inc_q};
   assign up_val  = (up_sum > {1'b0, hi_q}) ? hi_q : up_sum[PHASE_W-1:0];
   assign dn_val  = (dn_diff[PHASE_W] || (dn_diff[PHASE_W-1:0] < lo_q)) ? lo_q
                                                                       : dn_diff[PHASE_W-1:0];

   always_comb begin
      dir_d  = dir_q;
      step_d = phase_q;
      if (terminal && (mode_q == MODE_PING_PONG)) begin
         dir_d = ~dir_q;
      end
      if (terminal && (mode_q == MODE_REPEAT_UP)) begin
         step_d = lo_q;
      end else begin
         step_d = dir_d ? dn_val : up_val;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         mode_q    <= MODE_SINGLE_UP;
         lo_q      <= '0;
         hi_q      <= '0;
         inc_q     <= '0;
         dwell_q   <= '0;
         phase_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dir_q     <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (i_start && !i_stop) begin
                  if (cfg_bad) begin
                     cfg_err_q <= 1'b1;
                  end else begin
                     mode_q  <= sweep_mode_e'(i_mode);
                     lo_q    <= i_step_lo;
                     hi_q    <= i_step_hi;
                     inc_q   <= i_step_inc;
                     dwell_q <= i_dwell;
                     busy_q  <= 1'b1;
                     state_q <= ST_DWELL;
                     if (sweep_mode_e'(i_mode) == MODE_SINGLE_DOWN) begin
                        phase_q <= i_step_hi;
                        dir_q   <= 1'b1;
                     end else begin
                        phase_q <= i_step_lo;
                        dir_q   <= 1'b0;
                     end
                  end
               end
            end
            ST_DWELL: begin
               if (i_stop) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else if (tmr_expired) begin
                  if (terminal && ((mode_q == MODE_SINGLE_UP) ||
                                   (mode_q == MODE_SINGLE_DOWN))) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end else begin
                     state_q <= ST_WAIT_WRAP;
                  end
               end
            end
            ST_WAIT_WRAP: begin
               if (i_stop) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else if (i_wrap) begin
                  phase_q <= step_d;
                  dir_q   <= dir_d;
                  state_q <= ST_DWELL;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_phase_step = phase_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_dir        = dir_q;
   assign o_cfg_err    = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_wave_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wave_sweep_ctrl : directed scenarios plus random traffic against  |
// | a sweep-level reference model                                        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_wave_sweep_ctrl;

   localparam int PW = 10;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst, start, stop, wrap;
   logic [1:0]    mode;
   logic [PW-1:0] lo, hi, inc;
   logic [DW-1:0] dwell;
   logic [PW-1:0] o_phase_step;
   logic          o_busy, o_done, o_dir, o_cfg_err;

   always #5 clk = ~clk;

   wave_sweep_ctrl #(.PHASE_W(PW), .DWELL_W(DW)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_mode(mode),
      .i_step_lo(lo), .i_step_hi(hi), .i_step_inc(inc), .i_dwell(dwell), .i_wrap(wrap),
      .o_phase_step(o_phase_step), .o_busy(o_busy), .o_done(o_done), .o_dir(o_dir),
      .o_cfg_err(o_cfg_err)
   );

   int n_tot = 0;
   int n_bad = 0;

   // Reference model: a sweep is "active", shows a value for at least its dwell,
   // then waits for a wrap before moving to the next value of the sweep.
   int m_busy, m_phase, m_dir, m_done, m_err, m_wait, m_held;
   int c_mode, c_lo, c_hi, c_inc, c_dwell;

   int seen[$];
   bit rec;
   int last_ph, n_done, n_err;

   task automatic chk(input string tag, input int act, input int exp);
      n_tot++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_tick();
      int d, nxt;
      bit term;
      m_done = 0;
      m_err  = 0;
      if (rst) begin
         m_busy = 0; m_phase = 0; m_dir = 0; m_wait = 0; m_held = 0;
         c_mode = 0; c_lo = 0; c_hi = 0; c_inc = 0; c_dwell = 0;
      end else if (m_busy == 0) begin
         if (start && !stop) begin
            if (int'(lo) > int'(hi) || int'(inc) == 0) begin
               m_err = 1;
            end else begin
               c_mode = int'(mode); c_lo = int'(lo); c_hi = int'(hi);
               c_inc = int'(inc); c_dwell = int'(dwell);
               m_busy = 1; m_wait = 0; m_held = 1;
               m_dir   = (c_mode == 1) ? 1 : 0;
               m_phase = (c_mode == 1) ? c_hi : c_lo;
            end
         end
      end else if (stop) begin
         m_busy = 0;
      end else begin
         term = (m_dir == 1) ? (m_phase == c_lo) : (m_phase == c_hi);
         if (m_wait == 0) begin
            d = (c_dwell == 0) ? 1 : c_dwell;
            if (m_held >= d) begin
               if (term && c_mode < 2) begin
                  m_busy = 0;
                  m_done = 1;
               end else begin
                  m_wait = 1;
               end
            end else begin
               m_held++;
            end
         end else if (wrap) begin
            if (term && c_mode == 2) m_dir = 1 - m_dir;
            if (term && c_mode == 3) begin
               nxt = c_lo;
            end else if (m_dir == 1) begin
               nxt = m_phase - c_inc;
               if (nxt < c_lo) nxt = c_lo;
            end else begin
               nxt = m_phase + c_inc;
               if (nxt > c_hi) nxt = c_hi;
            end
            m_phase = nxt;
            m_wait  = 0;
            m_held  = 1;
         end
      end
   endtask

   task automatic step(input logic s, input logic p, input logic w);
      start = s; stop = p; wrap = w;
      @(posedge clk);
      model_tick();
      @(negedge clk);
      chk("phase", int'(o_phase_step), m_phase);
      chk("busy", int'(o_busy), m_busy);
      chk("done", int'(o_done), m_done);
      chk("dir", int'(o_dir), m_dir);
      chk("cfg_err", int'(o_cfg_err), m_err);
      if (rec) begin
         if (int'(o_phase_step) != last_ph) seen.push_back(int'(o_phase_step));
         last_ph = int'(o_phase_step);
         if (o_done) n_done++;
         if (o_cfg_err) n_err++;
      end
      start = 1'b0; stop = 1'b0; wrap = 1'b0;
   endtask

   task automatic cfg(input int md, input int l, input int h, input int st, input int dw);
      mode = 2'(md); lo = PW'(l); hi = PW'(h); inc = PW'(st); dwell = DW'(dw);
   endtask

   task automatic rec_on();
      seen.delete();
      last_ph = int'(o_phase_step);
      n_done = 0;
      n_err  = 0;
      rec    = 1'b1;
   endtask

   initial begin
      int e36[3] = '{10, 20, 30};
      int e37[5] = '{1000, 1020, 1023, 1000, 1020};
      int e38[6] = '{100, 110, 120, 110, 100, 110};
      int r;
      rec = 1'b0;
      rst = 1'b1; start = 1'b0; stop = 1'b0; wrap = 1'b0;
      cfg(0, 0, 0, 0, 0);
      @(negedge clk);
      step(0, 0, 0);
      step(1, 0, 1);
      rst = 1'b0;
      chk("rst_phase", int'(o_phase_step), 0);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_dir", int'(o_dir), 0);

      // single-up 10..30 with a wrap every 8 cycles
      cfg(0, 10, 30, 10, 4);
      rec_on();
      step(1, 0, 0);
      for (int i = 0; i < 60; i++) step(0, 0, (i % 8) == 7);
      rec = 1'b0;
      chk("up_len", seen.size(), 3);
      for (int i = 0; i < 3 && i < seen.size(); i++) chk("up_seq", seen[i], e36[i]);
      chk("up_done_cnt", n_done, 1);
      chk("up_busy_end", int'(o_busy), 0);
      chk("up_hold", int'(o_phase_step), 30);

      // rejected starts: inverted bounds, then zero increment
      rec_on();
      cfg(0, 50, 40, 5, 3);
      step(1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1);
      cfg(0, 5, 9, 0, 3);
      step(1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1);
      rec = 1'b0;
      chk("cfg_err_cnt", n_err, 2);
      chk("cfg_busy", int'(o_busy), 0);
      chk("cfg_phase", int'(o_phase_step), 30);

      // repeat-up near the top of the range
      cfg(3, 1000, 1023, 20, 1);
      rec_on();
      step(1, 0, 0);
      for (int i = 0; i < 60; i++) step(0, 0, (i % 8) == 7);
      rec = 1'b0;
      for (int i = 0; i < 5 && i < seen.size(); i++) chk("rpt_seq", seen[i], e37[i]);
      chk("rpt_len_ok", int'(seen.size() >= 5), 1);
      step(0, 1, 0);
      chk("rpt_stop_busy", int'(o_busy), 0);

      // ping-pong 100..120
      cfg(2, 100, 120, 10, 2);
      rec_on();
      step(1, 0, 0);
      for (int i = 0; i < 64; i++) step(0, 0, (i % 8) == 7);
      rec = 1'b0;
      for (int i = 0; i < 6 && i < seen.size(); i++) chk("pp_seq", seen[i], e38[i]);
      chk("pp_len_ok", int'(seen.size() >= 6), 1);
      step(0, 1, 0);
      chk("pp_stop_busy", int'(o_busy), 0);
      chk("pp_stop_done", int'(o_done), 0);

      // long wrap absence, then a single wrap
      cfg(3, 0, 500, 7, 2);
      step(1, 0, 0);
      for (int i = 0; i < 50; i++) step(0, 0, 0);
      chk("nowrap_hold", int'(o_phase_step), 0);
      step(0, 0, 1);
      chk("wrap_next", int'(o_phase_step), 7);
      step(0, 1, 0);

      // dwell 0 behaves as 1: done right after the first output cycle
      cfg(1, 5, 5, 1, 0);
      step(1, 0, 0);
      chk("dw0_first", int'(o_phase_step), 5);
      step(0, 0, 0);
      chk("dw0_done", int'(o_done), 1);

      // reset mid-sweep, then start+stop together from idle
      cfg(2, 100, 200, 5, 3);
      step(1, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1);
      rst = 1'b1;
      step(0, 0, 1);
      rst = 1'b0;
      chk("mid_rst_busy", int'(o_busy), 0);
      chk("mid_rst_phase", int'(o_phase_step), 0);
      chk("mid_rst_done", int'(o_done), 0);
      step(1, 1, 0);
      chk("startstop_busy", int'(o_busy), 0);
      step(0, 0, 0);
      chk("startstop_idle", int'(o_busy), 0);

      // random traffic, configuration inputs churn every cycle
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 499) == 0);
         r = int'($urandom_range(0, 1023));
         mode  = 2'($urandom_range(0, 3));
         lo    = PW'(r);
         hi    = ($urandom_range(0, 7) == 0) ? PW'($urandom_range(0, 1023))
                 : PW'((r + int'($urandom_range(0, 150)) > 1023) ? 1023
                       : r + int'($urandom_range(0, 150)));
         inc   = ($urandom_range(0, 9) == 0) ? PW'(0) : PW'($urandom_range(1, 80));
         dwell = DW'($urandom_range(0, 4));
         step($urandom_range(0, 19) == 0, $urandom_range(0, 79) == 0,
              $urandom_range(0, 3) == 0);
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
